// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game: FSM state encoding, sprite
// geometry and controller button bit positions.
package dino_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        DUCK   = 2'd3
    } dino_state_e;

    localparam int GROUND_Y    = 348;
    localparam int DINO_W      = 32;
    localparam int DINO_H      = 32;
    localparam int DUCK_H      = 16;
    localparam int JUMP_V0     = 12;
    localparam int GRAVITY     = 1;
    localparam int TICK_CYCLES = 500000;
    localparam int JUMP_BIT    = 0;
    localparam int DUCK_BIT    = 1;

endpackage

// File: rtl/dino_jump_ctrl_if.sv
// Signal bundle between the controller front end, the jump controller and the
// renderer/collision logic that consume the dino position.
interface dino_jump_ctrl_if;

    // No valid/ready handshake: inputs are sampled every clk and every output
    // is a registered level that is valid on every clk.
    logic [7:0]  controller_report;
    logic        game_over;
    logic [10:0] dino_y;
    logic [5:0]  dino_h;
    logic        airborne;
    logic        jump_start;
    logic [1:0]  state;

    modport master (
        output controller_report, game_over,
        input  dino_y, dino_h, airborne, jump_start, state
    );

    modport slave (
        input  controller_report, game_over,
        output dino_y, dino_h, airborne, jump_start, state
    );

endinterface

// File: rtl/dino_tick_gen.sv
// Free-running physics tick: one-clk pulse every TICK_CYCLES clks while
// enabled; the counter parks at zero while disabled.
module dino_tick_gen #(
    parameter int TICK_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dino_jump_ctrl.sv
// Dino vertical physics: turns the controller byte into sprite y / hitbox
// height using a tick-driven GROUND/RISE/FALL/DUCK state machine.
module dino_jump_ctrl #(
    parameter int GROUND_Y    = dino_pkg::GROUND_Y,
    parameter int JUMP_V0     = dino_pkg::JUMP_V0,
    parameter int GRAVITY     = dino_pkg::GRAVITY,
    parameter int TICK_CYCLES = dino_pkg::TICK_CYCLES,
    parameter int JUMP_BIT    = dino_pkg::JUMP_BIT,
    parameter int DUCK_BIT    = dino_pkg::DUCK_BIT
) (
    input  logic             clk,
    input  logic             reset,
    dino_jump_ctrl_if.slave  bus
);

    import dino_pkg::*;

    localparam logic [10:0] Y_GROUND = 11'(GROUND_Y);
    localparam logic [10:0] Y_DUCK   = 11'(GROUND_Y + DUCK_H);
    localparam logic [11:0] Y_LAND   = 12'(GROUND_Y);
    localparam logic [5:0]  V0       = 6'(JUMP_V0);
    localparam logic [5:0]  G1       = 6'(GRAVITY);
    localparam logic [5:0]  G2       = 6'(2 * GRAVITY);
    localparam logic [5:0]  H_NORM   = 6'(DINO_H);
    localparam logic [5:0]  H_DUCK   = 6'(DUCK_H);

    logic [1:0]  sync1, sync2;
    logic        jump_prev, go_q;
    logic        tick;
    dino_state_e state_q, state_d;
    logic [10:0] y_q, y_d;
    logic [5:0]  h_q, h_d;
    logic [5:0]  vel_q, vel_d;
    logic        pend_q, pend_d;
    logic        js_q, js_d;

    logic        jump_now, duck_now, jump_edge, go_fall;
    logic [11:0] rise_diff, fall_sum;
    logic [5:0]  fall_g;

    dino_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (!bus.game_over),
        .tick   (tick)
    );

    assign jump_now  = sync2[0];
    assign duck_now  = sync2[1];
    assign jump_edge = jump_now && !jump_prev;
    assign go_fall   = go_q && !bus.game_over;

    // 12-bit intermediates: bit 11 of the difference flags an upward overshoot.
    assign rise_diff = {1'b0, y_q} - {6'd0, vel_q};
    assign fall_sum  = {1'b0, y_q} + {6'd0, vel_q};
    assign fall_g    = duck_now ? G2 : G1;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        h_d     = h_q;
        vel_d   = vel_q;
        pend_d  = pend_q;
        js_d    = 1'b0;

        if (go_fall) begin
            state_d = GROUND;
            y_d     = Y_GROUND;
            h_d     = H_NORM;
            vel_d   = '0;
            pend_d  = 1'b0;
        end else if (bus.game_over) begin
            pend_d = 1'b0;
        end else begin
            // Presses only queue on the ground; in the air they are discarded.
            if (state_q == GROUND || state_q == DUCK) pend_d = pend_q || jump_edge;
            else                                       pend_d = 1'b0;

            if (tick) begin
                case (state_q)
                    GROUND: begin
                        if (pend_q) begin
                            state_d = RISE;
                            vel_d   = V0;
                            pend_d  = 1'b0;
                            js_d    = 1'b1;
                        end else if (duck_now) begin
                            state_d = DUCK;
                            h_d     = H_DUCK;
                            y_d     = Y_DUCK;
                        end
                    end
                    DUCK: begin
                        if (pend_q) begin
                            state_d = RISE;
                            h_d     = H_NORM;
                            y_d     = Y_GROUND;
                            vel_d   = V0;
                            pend_d  = 1'b0;
                            js_d    = 1'b1;
                        end else if (!duck_now) begin
                            state_d = GROUND;
                            h_d     = H_NORM;
                            y_d     = Y_GROUND;
                        end
                    end
                    RISE: begin
                        y_d = rise_diff[11] ? 11'd0 : rise_diff[10:0];
                        if (vel_q <= G1) begin
                            state_d = FALL;
                            vel_d   = '0;
                        end else begin
                            vel_d = vel_q - G1;
                        end
                    end
                    FALL: begin
                        if (fall_sum >= Y_LAND) begin
                            state_d = GROUND;
                            y_d     = Y_GROUND;
                            vel_d   = '0;
                        end else begin
                            y_d   = fall_sum[10:0];
                            vel_d = vel_q + fall_g;
                        end
                    end
                    default: state_d = GROUND;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            jump_prev <= 1'b0;
            go_q      <= 1'b0;
            state_q   <= GROUND;
            y_q       <= Y_GROUND;
            h_q       <= H_NORM;
            vel_q     <= '0;
            pend_q    <= 1'b0;
            js_q      <= 1'b0;
        end else begin
            sync1     <= {bus.controller_report[DUCK_BIT], bus.controller_report[JUMP_BIT]};
            sync2     <= sync1;
            jump_prev <= jump_now;
            go_q      <= bus.game_over;
            state_q   <= state_d;
            y_q       <= y_d;
            h_q       <= h_d;
            vel_q     <= vel_d;
            pend_q    <= pend_d;
            js_q      <= js_d;
        end
    end

    assign bus.dino_y     = y_q;
    assign bus.dino_h     = h_q;
    assign bus.airborne   = (state_q == RISE) || (state_q == FALL);
    assign bus.jump_start = js_q;
    assign bus.state      = state_q;

endmodule
